// File: rtl/draw_pkg.sv
// Shared types and constants for the sprite draw scheduler.
package draw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Cycles spent after the last ROM address so the pixel pipeline empties.
  localparam int DRAIN_CYCLES = 2;

  localparam int DEF_SPR_W    = 5;
  localparam int DEF_SPR_H    = 5;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_draw_scheduler_if.sv
// Requester, ROM and plot-port bundle of the sprite draw scheduler.
interface sprite_draw_scheduler_if #(
  parameter int N_REQ   = 2,
  parameter int X_W     = 8,
  parameter int Y_W     = 7,
  parameter int ROM_AW  = 8,
  parameter int COLOR_W = 8
);

  logic [N_REQ-1:0]        req;
  logic [N_REQ*X_W-1:0]    req_x0;
  logic [N_REQ*Y_W-1:0]    req_y0;
  logic [N_REQ*ROM_AW-1:0] req_base;
  logic [N_REQ-1:0]        grant;
  logic [N_REQ-1:0]        done;
  logic                    busy;
  logic [ROM_AW-1:0]       rom_addr;
  logic [COLOR_W-1:0]      rom_data;
  logic                    plot;
  logic [X_W-1:0]          plot_x;
  logic [Y_W-1:0]          plot_y;
  logic [COLOR_W-1:0]      plot_color;

  // Scheduler side.
  modport slave (
    input  req, req_x0, req_y0, req_base, rom_data,
    output grant, done, busy, rom_addr, plot, plot_x, plot_y, plot_color
  );

  // Requester / ROM / frame-buffer side.
  modport master (
    output req, req_x0, req_y0, req_base, rom_data,
    input  grant, done, busy, rom_addr, plot, plot_x, plot_y, plot_color
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts one past the last granted index.
module rr_arbiter
  import draw_pkg::*;
#(
  parameter  int N_REQ = 2,
  localparam int IW    = clog2_min1(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  output logic [N_REQ-1:0] gnt,
  output logic [IW-1:0]    gnt_idx,
  output logic             any
);

  logic [IW-1:0] ptr_q;
  logic [IW-1:0] ptr_d;
  logic [IW:0]   cand_s;

  // Pick the first requester at or after the pointer, wrapping around.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand_s  = '0;
    for (int off = 0; off < N_REQ; off++) begin
      cand_s = {1'b0, ptr_q} + (IW+1)'(off);
      if (cand_s >= (IW+1)'(N_REQ)) begin
        cand_s = cand_s - (IW+1)'(N_REQ);
      end else begin
        cand_s = cand_s;
      end
      if (!any && req[cand_s[IW-1:0]]) begin
        any     = 1'b1;
        gnt_idx = cand_s[IW-1:0];
      end else begin
        gnt_idx = gnt_idx;
      end
    end
    if (any) begin
      gnt[gnt_idx] = 1'b1;
    end else begin
      gnt = '0;
    end
  end

  // Move the pointer past the winner whenever a grant is taken.
  always_comb begin
    if (update && any) begin
      ptr_d = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; requester 0 has top priority after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sprite_draw_scheduler.sv
// Arbitrates sprite draw requests and sweeps the winning sprite through
// a synchronous ROM into clipped, transparency-filtered plot writes.
module sprite_draw_scheduler
  import draw_pkg::*;
#(
  parameter int N_REQ       = 2,
  parameter int SPR_W       = DEF_SPR_W,
  parameter int SPR_H       = DEF_SPR_H,
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int SCREEN_W    = DEF_SCREEN_W,
  parameter int SCREEN_H    = DEF_SCREEN_H,
  parameter int ROM_AW      = 8,
  parameter int COLOR_W     = 8,
  parameter int TRANSPARENT = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  sprite_draw_scheduler_if.slave  bus
);

  localparam int IW  = clog2_min1(N_REQ);
  localparam int CXW = clog2_min1(SPR_W);
  localparam int CYW = clog2_min1(SPR_H);
  localparam int DW  = clog2_min1(DRAIN_CYCLES);

  state_e             state_q, state_d;
  logic [CXW-1:0]     cx_q, cx_d;
  logic [CYW-1:0]     cy_q, cy_d;
  logic [DW-1:0]      drain_q, drain_d;
  logic [X_W-1:0]     x0_q, x0_d;
  logic [Y_W-1:0]     y0_q, y0_d;
  logic [ROM_AW-1:0]  base_q, base_d;
  logic [IW-1:0]      owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               busy_q, busy_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic               s1_valid_q, s1_valid_d;
  logic [CXW-1:0]     s1_cx_q, s1_cx_d;
  logic [CYW-1:0]     s1_cy_q, s1_cy_d;
  logic               plot_q, plot_d;
  logic [X_W-1:0]     plot_x_q, plot_x_d;
  logic [Y_W-1:0]     plot_y_q, plot_y_d;
  logic [COLOR_W-1:0] plot_color_q, plot_color_d;

  logic [N_REQ-1:0]   arb_gnt_s;
  logic [IW-1:0]      arb_idx_s;
  logic               arb_any_s;
  logic               arb_update_s;
  logic [X_W-1:0]     sel_x0_s;
  logic [Y_W-1:0]     sel_y0_s;
  logic [ROM_AW-1:0]  sel_base_s;
  logic               last_pixel_s;
  logic               cx_wrap_s;
  logic [X_W:0]       sum_x_s;
  logic [Y_W:0]       sum_y_s;

  assign arb_update_s = (state_q == IDLE);

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req),
    .update  (arb_update_s),
    .gnt     (arb_gnt_s),
    .gnt_idx (arb_idx_s),
    .any     (arb_any_s)
  );

  // Extract the winning requester's origin and ROM base.
  always_comb begin
    sel_x0_s   = '0;
    sel_y0_s   = '0;
    sel_base_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (IW'(i) == arb_idx_s) begin
        sel_x0_s   = bus.req_x0[i*X_W +: X_W];
        sel_y0_s   = bus.req_y0[i*Y_W +: Y_W];
        sel_base_s = bus.req_base[i*ROM_AW +: ROM_AW];
      end else begin
        sel_x0_s = sel_x0_s;
      end
    end
  end

  assign cx_wrap_s    = (cx_q == CXW'(SPR_W - 1));
  assign last_pixel_s = cx_wrap_s && (cy_q == CYW'(SPR_H - 1));

  // Sequencing: accept a request, sweep the sprite, drain the pipeline.
  always_comb begin
    state_d    = state_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    drain_d    = drain_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    base_d     = base_q;
    owner_d    = owner_q;
    grant_d    = '0;
    done_d     = '0;
    rom_addr_d = rom_addr_q;
    s1_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_any_s) begin
          grant_d    = arb_gnt_s;
          x0_d       = sel_x0_s;
          y0_d       = sel_y0_s;
          base_d     = sel_base_s;
          owner_d    = arb_idx_s;
          cx_d       = '0;
          cy_d       = '0;
          rom_addr_d = sel_base_s;
          state_d    = DRAW;
        end else begin
          state_d = IDLE;
        end
      end
      DRAW: begin
        s1_valid_d = 1'b1;
        if (last_pixel_s) begin
          drain_d = '0;
          state_d = DRAIN;
        end else begin
          if (cx_wrap_s) begin
            cx_d = '0;
            cy_d = cy_q + CYW'(1);
          end else begin
            cx_d = cx_q + CXW'(1);
          end
          // Linear address; overflow past 2^ROM_AW wraps by truncation.
          rom_addr_d = base_q + ROM_AW'(cy_d) * ROM_AW'(SPR_W) + ROM_AW'(cx_d);
        end
      end
      DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
          drain_d = '0;
          state_d = IDLE;
        end else begin
          drain_d = drain_q + DW'(1);
          // Registered one cycle early so done lines up with the last plot.
          if (drain_q == DW'(DRAIN_CYCLES - 2)) begin
            done_d[owner_q] = 1'b1;
          end else begin
            done_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  assign sum_x_s = {1'b0, x0_q} + (X_W+1)'(s1_cx_q);
  assign sum_y_s = {1'b0, y0_q} + (Y_W+1)'(s1_cy_q);

  // Pixel pipeline: stage 1 tracks the ROM read, stage 2 clips and plots.
  always_comb begin
    s1_cx_d      = cx_q;
    s1_cy_d      = cy_q;
    plot_d       = 1'b0;
    plot_x_d     = plot_x_q;
    plot_y_d     = plot_y_q;
    plot_color_d = plot_color_q;
    if (s1_valid_q) begin
      plot_d       = (sum_x_s < (X_W+1)'(SCREEN_W)) &&
                     (sum_y_s < (Y_W+1)'(SCREEN_H)) &&
                     (bus.rom_data != COLOR_W'(TRANSPARENT));
      plot_x_d     = sum_x_s[X_W-1:0];
      plot_y_d     = sum_y_s[Y_W-1:0];
      plot_color_d = bus.rom_data;
    end else begin
      plot_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cx_q         <= '0;
      cy_q         <= '0;
      drain_q      <= '0;
      x0_q         <= '0;
      y0_q         <= '0;
      base_q       <= '0;
      owner_q      <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      busy_q       <= 1'b0;
      rom_addr_q   <= '0;
      s1_valid_q   <= 1'b0;
      s1_cx_q      <= '0;
      s1_cy_q      <= '0;
      plot_q       <= 1'b0;
      plot_x_q     <= '0;
      plot_y_q     <= '0;
      plot_color_q <= '0;
    end else begin
      state_q      <= state_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      drain_q      <= drain_d;
      x0_q         <= x0_d;
      y0_q         <= y0_d;
      base_q       <= base_d;
      owner_q      <= owner_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      rom_addr_q   <= rom_addr_d;
      s1_valid_q   <= s1_valid_d;
      s1_cx_q      <= s1_cx_d;
      s1_cy_q      <= s1_cy_d;
      plot_q       <= plot_d;
      plot_x_q     <= plot_x_d;
      plot_y_q     <= plot_y_d;
      plot_color_q <= plot_color_d;
    end
  end

  assign bus.grant      = grant_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.rom_addr   = rom_addr_q;
  assign bus.plot       = plot_q;
  assign bus.plot_x     = plot_x_q;
  assign bus.plot_y     = plot_y_q;
  assign bus.plot_color = plot_color_q;

endmodule
